// File: rtl/dram_timing_pkg.sv
// Shared types, constants and helpers for the banked open-row memory responder.
package dram_timing_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef enum logic [1:0] {
        BANK_HIT,
        BANK_CLOSED,
        BANK_CONFLICT
    } bank_state_e;

    localparam logic [63:0] UNWRITTEN_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic int row_bits(input int depth_bits, input int col_bits, input int bank_bits);
        return depth_bits - col_bits - bank_bits;
    endfunction

    // Total access latency in cycles for the bank state seen on the accept edge.
    function automatic int latency(input bank_state_e st, input int t_cas, input int t_rcd,
                                   input int t_rp);
        case (st)
            BANK_HIT:    return t_cas;
            BANK_CLOSED: return t_rcd + t_cas;
            default:     return t_rp + t_rcd + t_cas;
        endcase
    endfunction

endpackage

// File: rtl/dram_bank.sv
// One DRAM bank: tracks its open row and classifies a presented row as hit, closed or conflict.
module dram_bank #(
    parameter int ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROW_BITS-1:0] row_i,
    input  logic                upd_i,
    input  logic                open_i,
    input  logic [ROW_BITS-1:0] upd_row_i,
    output logic                hit_o,
    output logic                closed_o,
    output logic                conflict_o
);

    logic                open_q;
    logic [ROW_BITS-1:0] row_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= 1'b0;
            row_q  <= '0;
        end else if (upd_i) begin
            open_q <= open_i;
            row_q  <= upd_row_i;
        end
    end

    assign hit_o      = open_q && (row_q == row_i);
    assign closed_o   = !open_q;
    assign conflict_o = open_q && (row_q != row_i);

endmodule

// File: rtl/dram_timing.sv
// Memory-side responder with banked open-row timing and row hit/miss counters.
module dram_timing
    import dram_timing_pkg::*;
#(
    parameter int DEPTH_BITS  = 10,
    parameter int COL_BITS    = 3,
    parameter int BANK_BITS   = 2,
    parameter int T_CAS       = 1,
    parameter int T_RCD       = 2,
    parameter int T_RP        = 2,
    parameter bit CLOSED_PAGE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] din,
    output logic [63:0] dout,
    input  logic        re,
    input  logic        we,
    output logic        ready,
    output logic [31:0] row_hit_count,
    output logic [31:0] row_miss_count
);

    localparam int ROW_BITS  = row_bits(DEPTH_BITS, COL_BITS, BANK_BITS);
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int WORDS     = 1 << DEPTH_BITS;
    localparam int CNT_BITS  = $clog2(T_RP + T_RCD + T_CAS) + 1;

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [DEPTH_BITS-1:0] idx_q;
    logic [63:0]           din_q;
    logic                  write_q;
    logic                  hit_q;
    logic [63:0]           dout_q;
    logic [31:0]           hit_cnt_q, miss_cnt_q;
    logic [WORDS-1:0]      valid_q;
    logic [63:0]           mem [WORDS];

    logic                  accept, complete;
    bank_state_e           acc_state;
    logic [NUM_BANKS-1:0]  bank_hit, bank_closed, bank_conflict;
    logic                  unused_addr;

    wire [BANK_BITS-1:0] req_bank = addr[COL_BITS+BANK_BITS-1:COL_BITS];
    wire [ROW_BITS-1:0]  req_row  = addr[DEPTH_BITS-1:COL_BITS+BANK_BITS];
    wire [BANK_BITS-1:0] cur_bank = idx_q[COL_BITS+BANK_BITS-1:COL_BITS];
    wire [ROW_BITS-1:0]  cur_row  = idx_q[DEPTH_BITS-1:COL_BITS+BANK_BITS];

    // Aliasing: address bits above the storage index are deliberately ignored.
    assign unused_addr = ^addr[63:DEPTH_BITS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dram_bank #(.ROW_BITS(ROW_BITS)) u_bank (
            .clk        (clk),
            .rst        (rst),
            .row_i      (req_row),
            .upd_i      (complete && (cur_bank == BANK_BITS'(b))),
            .open_i     (!CLOSED_PAGE),
            .upd_row_i  (cur_row),
            .hit_o      (bank_hit[b]),
            .closed_o   (bank_closed[b]),
            .conflict_o (bank_conflict[b])
        );
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        acc_state = BANK_CLOSED;
        case (1'b1)
            bank_hit[req_bank]:      acc_state = BANK_HIT;
            bank_closed[req_bank]:   acc_state = BANK_CLOSED;
            bank_conflict[req_bank]: acc_state = BANK_CONFLICT;
            default:                 acc_state = BANK_CLOSED;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (re || we) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_BITS'(latency(acc_state, T_CAS, T_RCD, T_RP) - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            din_q      <= '0;
            write_q    <= 1'b0;
            hit_q      <= 1'b0;
            dout_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= addr[DEPTH_BITS-1:0];
                din_q   <= din;
                write_q <= we;
                hit_q   <= (acc_state == BANK_HIT);
            end
            if (complete) begin
                if (write_q) begin
                    valid_q[idx_q] <= 1'b1;
                end else begin
                    dout_q <= valid_q[idx_q] ? mem[idx_q] : UNWRITTEN_DATA;
                end
                if (hit_q) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    // NOTE: the storage array is not reset; valid_q alone decides whether a word holds data.
    always_ff @(posedge clk) begin
        if (!rst && complete && write_q) begin
            mem[idx_q] <= din_q;
        end
    end

    assign ready          = (state_q == IDLE);
    assign dout           = dout_q;
    assign row_hit_count  = hit_cnt_q;
    assign row_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dram_timing.sv
// Self-checking bench for dram_timing: directed scenarios plus random traffic against a bank/row model.
module tb_dram_timing;

    localparam int T_CAS = 1;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr, din, dout;
    logic        re, we, ready;
    logic [31:0] row_hit_count, row_miss_count;

    int total = 0;
    int bad   = 0;

    // Reference model: open row per bank, sparse storage, expected dout and counters.
    bit          m_open [4];
    int          m_row  [4];
    logic [63:0] m_mem  [int];
    logic [63:0] m_dout;
    int          m_hit, m_miss;

    dram_timing u_dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .din            (din),
        .dout           (dout),
        .re             (re),
        .we             (we),
        .ready          (ready),
        .row_hit_count  (row_hit_count),
        .row_miss_count (row_miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 1'b0;
            m_row[b]  = 0;
        end
        m_mem.delete();
        m_dout = 64'd0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input bit is_wr, input logic [63:0] a, input logic [63:0] d,
                                output int lat);
        int idx, bank, row;
        idx  = int'(a[9:0]);
        bank = (idx / 8) % 4;
        row  = idx / 32;
        if (m_open[bank] && m_row[bank] == row) begin
            lat = T_CAS;
            m_hit++;
        end else if (!m_open[bank]) begin
            lat = T_RCD + T_CAS;
            m_miss++;
        end else begin
            lat = T_RP + T_RCD + T_CAS;
            m_miss++;
        end
        m_open[bank] = 1'b1;
        m_row[bank]  = row;
        if (is_wr) m_mem[idx] = d;
        else m_dout = m_mem.exists(idx) ? m_mem[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // Issue one request from a negedge with ready high; returns the observed busy length.
    task automatic do_req(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d,
                          input bit pulse_busy, input string tag, output int n);
        int          exp_lat;
        logic [63:0] prev_dout;
        prev_dout = m_dout;
        check({tag, " ready_before"}, 64'(ready), 64'd1);
        re   = rd;
        we   = wr;
        addr = a;
        din  = d;
        model_access(wr, a, d, exp_lat);
        @(posedge clk);
        @(negedge clk);
        re   = 1'b0;
        we   = 1'b0;
        addr = {$urandom, $urandom};
        din  = {$urandom, $urandom};
        n = 0;
        while (!ready && n < 64) begin
            n++;
            if (n == 1) check({tag, " dout_busy"}, dout, prev_dout);
            if (pulse_busy && n == 1) re = 1'b1;
            if (pulse_busy && n == 2) re = 1'b0;
            @(negedge clk);
        end
        re = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " dout"}, dout, m_dout);
        check({tag, " hits"}, 64'(row_hit_count), 64'(m_hit));
        check({tag, " misses"}, 64'(row_miss_count), 64'(m_miss));
    endtask

    initial begin
        int          n;
        logic [63:0] a, d;
        int          op;

        rst  = 1'b1;
        re   = 1'b0;
        we   = 1'b0;
        addr = '0;
        din  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", 64'(ready), 64'd1);
        check("reset dout", dout, 64'd0);
        check("reset hits", 64'(row_hit_count), 64'd0);
        check("reset misses", 64'(row_miss_count), 64'd0);

        do_req(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, "rd0", n);
        check("rd0 closed latency", 64'(n), 64'd3);
        check("rd0 all ones", dout, 64'hFFFF_FFFF_FFFF_FFFF);

        do_req(1'b0, 1'b1, 64'd1, 64'h0123456789abcdef, 1'b0, "wr1", n);
        check("wr1 hit latency", 64'(n), 64'd1);
        do_req(1'b1, 1'b0, 64'd1, 64'd0, 1'b0, "rd1", n);
        check("rd1 hit count", 64'(row_hit_count), 64'd2);

        do_req(1'b0, 1'b1, 64'd257, 64'd123, 1'b0, "wr257", n);
        check("wr257 conflict latency", 64'(n), 64'd5);
        do_req(1'b1, 1'b0, 64'd1, 64'd0, 1'b0, "rd1b", n);
        check("rd1b conflict latency", 64'(n), 64'd5);
        do_req(1'b1, 1'b0, 64'd257, 64'd0, 1'b0, "rd257", n);
        check("rd257 data", dout, 64'd123);

        // Simultaneous re/we acts as a write; a re pulse while busy must be ignored.
        do_req(1'b1, 1'b1, 64'd8, 64'd7, 1'b1, "rw8", n);
        check("rw8 dout kept", dout, 64'd123);
        do_req(1'b1, 1'b0, 64'd8, 64'd0, 1'b0, "rd8", n);
        check("rd8 data", dout, 64'd7);

        // Reset in the middle of a conflicting write; the write must not commit.
        we   = 1'b1;
        addr = 64'd300;
        din  = 64'd55;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        check("rst300 busy", 64'(ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst ready", 64'(ready), 64'd1);
        check("midrst dout", dout, 64'd0);
        check("midrst hits", 64'(row_hit_count), 64'd0);
        check("midrst misses", 64'(row_miss_count), 64'd0);
        model_reset();
        do_req(1'b1, 1'b0, 64'd300, 64'd0, 1'b0, "rd300", n);
        check("rd300 all ones", dout, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random traffic over a few rows per bank, with junk in the aliased upper bits.
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            a[9:0] = {5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            d  = {$urandom, $urandom};
            op = $urandom_range(0, 2);
            do_req(op != 1, op != 0, a, d, ($urandom_range(0, 3) == 0), "rand", n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/dram_timing.md
Name: dram_timing

Overview:
- Synthesizable memory-side responder for the 64-bit addr/din/dout/re/we/ready memory protocol; the far end of the chain that cache, spm, split and combine initiate into.
- Drop-in alternative to the flat ram model.
- Adds banked open-row timing: row hit, closed bank and row conflict each give a distinct, deterministic latency.
- Exports row-hit and row-miss counters for the simulator's cost model.

Parameters:
- DEPTH_BITS, 10, log2 of storage words; storage index is addr[DEPTH_BITS-1:0], higher address bits are ignored (aliasing).
- COL_BITS, 3, column field, addr[COL_BITS-1:0].
- BANK_BITS, 2, bank field, addr[COL_BITS+BANK_BITS-1:COL_BITS].
- T_CAS, 1, cycles for a row-hit access; must be at least 1.
- T_RCD, 2, activate cycles added when the bank has no open row.
- T_RP, 2, precharge cycles added on a row conflict.
- CLOSED_PAGE, 0, 1 = close the row after every access (no row hits possible).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  64  word address, sampled on the accept edge.
- din  in  64  write data, sampled on the accept edge.
- dout  out  64  read data.
- re  in  1  read request.
- we  in  1  write request.
- ready  out  1  idle and able to accept a request.
- row_hit_count  out  32  accesses that hit an open row; saturates.
- row_miss_count  out  32  closed-bank plus conflict accesses; saturates.

Behaviour:
- Reset values: ready=1, dout=0, both counters 0, all banks closed, all word-valid bits cleared.
- Accept: a rising edge where ready=1 and (re|we)=1.
  - we has priority; re=we=1 is treated as a write only.
  - addr and din are latched on the accept edge.
  - re/we while ready=0 are ignored; they are not queued.
- Row field: addr[DEPTH_BITS-1:COL_BITS+BANK_BITS]. Constraint: COL_BITS+BANK_BITS < DEPTH_BITS.
- Latency L, chosen from the target bank state on the accept edge:
  - open row equal to the request row: L = T_CAS (hit).
  - bank closed: L = T_RCD + T_CAS (miss).
  - different row open: L = T_RP + T_RCD + T_CAS (miss).
- Handshake timing, accept at edge k:
  - ready=0 after edges k through k+L-1.
  - ready=1 after edge k+L (the completion edge).
  - The initiator may issue a new request on the completion edge +1, i.e. back-to-back with no dead cycle.
- States:
  - IDLE: accepts requests.
  - BUSY: down-counter loaded with L-1; counts down, and completes when the counter is 0.
  - Then returns to IDLE.
- Completion edge actions:
  - write: storage[idx] <= din and valid[idx] <= 1.
  - read: dout <= storage[idx] if valid[idx], else 64'hFFFF_FFFF_FFFF_FFFF.
  - bank open row <= request row; with CLOSED_PAGE=1 the bank is marked closed instead.
  - The matching counter increments on the completion edge.
- dout holds its value until the next read completes; writes do not change dout.
- Counters stop at 32'hFFFF_FFFF and do not wrap.
- Reset mid-operation:
  - the in-flight access is discarded; a pending write does not commit.
  - ready=1 after the reset edge; all other reset values apply.
- rst has priority over a simultaneous accept.

Decomposition:
- Package dram_timing_pkg holds:
  - field-width derivations (ROW_BITS = DEPTH_BITS-COL_BITS-BANK_BITS);
  - the state enum IDLE/BUSY;
  - the all-ones unwritten-data constant;
  - a latency function (bank_state, T_*) -> L.
- Sub-module dram_bank, instantiated 2^BANK_BITS times:
  - holds the open-row register and open flag;
  - outputs hit/closed/conflict for a presented row;
  - is updated on the completion edge with an open/close command.

Test Plan:
- Reset, then idle cycle -> ready=1, dout=0, both counters 0.
- Read of unwritten addr 0 -> ready low for 3 cycles (T_RCD+T_CAS), then ready=1, dout=64'hFFFFFFFFFFFFFFFF, row_miss_count=1.
- Write addr 1 <- 64'h0123456789abcdef, then read addr 1 -> write takes 1 cycle (row already open from the addr 0 read); read is a hit, ready low exactly 1 cycle, dout=64'h0123456789abcdef, row_hit_count=2.
- Write addr 257 <- 123 (same bank, different row), then read addr 1 -> write ready low 5 cycles (conflict); read ready low 5 cycles; dout=64'h0123456789abcdef; 257 then reads back 123.
- Pulse re while busy, and assert re=we=1 with din=7 at addr 8 -> busy pulse ignored (no extra access, counters unchanged); simultaneous request acts as a write, so a read of addr 8 returns 7 and dout is unchanged until that read completes.
- Assert rst=1 during a 5-cycle write to addr 300 -> ready=1 after the reset edge; a read of 300 returns all-ones; counters are 0.
